// File: rtl/csr_file_irq.sv
// ---------------------------------------------------------------------------
// csr_file_irq
//
// Machine-mode CSR file for the RV32 core. It provides mstatus (MIE/MPIE,
// MPP hard-wired to M), mie, mtvec, mscratch, mepc, mcause and a read-only mip
// that samples NUM_IRQ level interrupt lines. It handles trap entry and mret,
// and it drives a prioritised interrupt request toward the core.
//
// Optional build macro: CSR_COUNTERS_EN
//   Adds the 64-bit mcycle (0xB00/0xB80) and minstret (0xB02/0xB82) counters.
//   When the macro is undefined, these addresses read 0 and ignore writes.
//
// Ports
//   clk         in   clock
//   reset       in   synchronous active-high reset
//   irq         in   [NUM_IRQ] level interrupt sources
//   we          in   CSR write strobe
//   addr        in   [12] CSR address
//   din         in   [32] CSR write data
//   trap        in   one-cycle pulse: take trap now
//   trap_pc     in   [32] pc saved in mepc on trap
//   trap_cause  in   [32] value saved in mcause on trap
//   mret        in   one-cycle pulse: return from trap
//   instret     in   one instruction retired this cycle
//   dout        out  [32] combinational read data for addr
//   mtvec_out   out  [32] current trap vector
//   mepc_out    out  [32] current mepc
//   irq_req     out  enabled interrupt pending and mstatus.MIE=1
//   irq_cause   out  [32] mcause for the highest-priority pending interrupt
// ---------------------------------------------------------------------------
module csr_file_irq #(
    parameter int          NUM_IRQ     = 2,
    parameter logic [31:0] MTVEC_RESET = 32'h2000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               we,
    input  logic [11:0]        addr,
    input  logic [31:0]        din,
    input  logic               trap,
    input  logic [31:0]        trap_pc,
    input  logic [31:0]        trap_cause,
    input  logic               mret,
    input  logic               instret,
    output logic [31:0]        dout,
    output logic [31:0]        mtvec_out,
    output logic [31:0]        mepc_out,
    output logic               irq_req,
    output logic [31:0]        irq_cause
);

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MIP      = 12'h344;

    // Map the interrupt lines onto their mip/mie bit positions:
    // line 0 -> MTI (bit 7), line 1 -> MEI (bit 11), line k>=2 -> bit 16+k-2.
    function automatic logic [31:0] irq_to_bits(input logic [NUM_IRQ-1:0] v);
        logic [31:0] r;
        r     = '0;
        r[7]  = v[0];
        r[11] = v[1];
        for (int k = 2; k < NUM_IRQ; k++) begin
            r[14+k] = v[k];
        end
        return r;
    endfunction

    localparam logic [31:0] IMPL_MASK = irq_to_bits({NUM_IRQ{1'b1}});

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic        st_mie_q,  st_mie_d;
    logic        st_mpie_q, st_mpie_d;
    logic [31:0] mie_q,      mie_d;
    logic [31:0] mip_q,      mip_d;
    logic [31:0] mtvec_q,    mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q,     mepc_d;
    logic [31:0] mcause_q,   mcause_d;

    logic wr_mstatus, wr_mie, wr_mtvec, wr_mscratch, wr_mepc, wr_mcause;

    assign wr_mstatus  = we && (addr == A_MSTATUS);
    assign wr_mie      = we && (addr == A_MIE);
    assign wr_mtvec    = we && (addr == A_MTVEC);
    assign wr_mscratch = we && (addr == A_MSCRATCH);
    assign wr_mepc     = we && (addr == A_MEPC);
    assign wr_mcause   = we && (addr == A_MCAUSE);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here receives a default first. Without
        // that default, a path that does not assign the signal would infer
        // a latch.
        st_mie_d   = st_mie_q;
        st_mpie_d  = st_mpie_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mip_d      = irq_to_bits(irq);

        // Trap has priority over mret, and both have priority over
        // software writes to mstatus.
        if (trap) begin
            st_mpie_d = st_mie_q;
            st_mie_d  = 1'b0;
        end else if (mret) begin
            st_mie_d  = st_mpie_q;
            st_mpie_d = 1'b1;
        end else if (wr_mstatus) begin
            st_mie_d  = din[3];
            st_mpie_d = din[7];
        end

        if (trap) begin
            mepc_d   = trap_pc & ~32'h3;
            mcause_d = trap_cause;
        end else begin
            if (wr_mepc)   mepc_d   = din & ~32'h3;
            if (wr_mcause) mcause_d = din;
        end

        // These CSRs are not touched by trap, so their writes always complete.
        if (wr_mie)      mie_d      = din & IMPL_MASK;
        if (wr_mtvec)    mtvec_d    = din & ~32'h3;
        if (wr_mscratch) mscratch_d = din;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so all
        // registers update together from values sampled before the edge.
        if (reset) begin
            st_mie_q   <= 1'b0;
            st_mpie_q  <= 1'b0;
            mie_q      <= '0;
            mip_q      <= '0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
        end else begin
            st_mie_q   <= st_mie_d;
            st_mpie_q  <= st_mpie_d;
            mie_q      <= mie_d;
            mip_q      <= mip_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
        end
    end

`ifdef CSR_COUNTERS_EN
    // ------------------------------------------------------------------
    // mcycle / minstret. A write to one half reloads that half, keeps the
    // other half and skips the increment for that cycle.
    // ------------------------------------------------------------------
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;

    logic [63:0] mcycle_q,   mcycle_d;
    logic [63:0] minstret_q, minstret_d;

    always_comb begin
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = instret ? (minstret_q + 64'd1) : minstret_q;
        if (we) begin
            case (addr)
                A_MCYCLE:    mcycle_d   = {mcycle_q[63:32], din};
                A_MCYCLEH:   mcycle_d   = {din, mcycle_q[31:0]};
                A_MINSTRET:  minstret_d = {minstret_q[63:32], din};
                A_MINSTRETH: minstret_d = {din, minstret_q[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end
`else
    // instret only feeds the counters, so it is unused in this build.
    logic unused_instret;
    assign unused_instret = instret;
`endif

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    always_comb begin
        dout = '0;
        case (addr)
            A_MSTATUS:  dout = {19'b0, 2'b11, 3'b0, st_mpie_q, 3'b0, st_mie_q, 3'b0};
            A_MIE:      dout = mie_q;
            A_MTVEC:    dout = mtvec_q;
            A_MSCRATCH: dout = mscratch_q;
            A_MEPC:     dout = mepc_q;
            A_MCAUSE:   dout = mcause_q;
            A_MIP:      dout = mip_q;
`ifdef CSR_COUNTERS_EN
            A_MCYCLE:    dout = mcycle_q[31:0];
            A_MCYCLEH:   dout = mcycle_q[63:32];
            A_MINSTRET:  dout = minstret_q[31:0];
            A_MINSTRETH: dout = minstret_q[63:32];
`endif
            default:    dout = '0;
        endcase
    end

    assign mtvec_out = mtvec_q;
    assign mepc_out  = mepc_q;

    // ------------------------------------------------------------------
    // Interrupt request and priority encoding
    // ------------------------------------------------------------------
    logic [31:0] pend;
    logic [4:0]  cause_code;

    assign pend    = mip_q & mie_q;
    assign irq_req = st_mie_q & (|pend);

    always_comb begin
        cause_code = 5'd0;
        if (pend[11]) begin
            cause_code = 5'd11;
        end else if (pend[7]) begin
            cause_code = 5'd7;
        end else begin
            // Scan from the top down so the lowest-index platform line wins.
            for (int k = NUM_IRQ - 1; k >= 2; k--) begin
                if (pend[14+k]) cause_code = 5'(14 + k);
            end
        end
    end

    assign irq_cause = {1'b1, 26'b0, cause_code};

endmodule

// File: doc/csr_file_irq.md
Name: csr_file_irq

Overview:
- Parametrised machine-mode CSR file for the RV32 core; successor to the single-timer-interrupt CSR block.
- Adds a configurable number of interrupt lines and per-source enables (mie CSR).
- Adds a full trap entry/return sequence (mepc, mcause, MPIE stacking, mret), mscratch and a writable mtvec.
- Sits beside the decode/execute stage; the core drives trap/mret pulses and CSR instruction accesses, and the block returns read data, trap vector and a prioritised interrupt request.

Parameters:
- NUM_IRQ, 2, number of interrupt inputs (2..18). irq[0]=MTI (mip bit 7), irq[1]=MEI (mip bit 11), irq[k>=2] maps to platform bit 16+k-2.
- MTVEC_RESET, 32'h2000, mtvec value after reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- irq  in  NUM_IRQ  level interrupt sources
- we  in  1  CSR write strobe
- addr  in  12  CSR address
- din  in  32  CSR write data
- trap  in  1  one-cycle pulse: take trap now
- trap_pc  in  32  pc to save in mepc on trap
- trap_cause  in  32  value to save in mcause on trap
- mret  in  1  one-cycle pulse: return from trap
- instret  in  1  one instruction retired this cycle
- dout  out  32  combinational read data for addr
- mtvec_out  out  32  current trap vector
- mepc_out  out  32  current mepc
- irq_req  out  1  enabled interrupt pending and mstatus.MIE=1
- irq_cause  out  32  mcause value for highest-priority request: {1'b1, 26'b0, code}

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (reset).
- Reset state: MIE=0, MPIE=0, mie=0, mip=0, mepc=0, mcause=0, mscratch=0, mtvec=MTVEC_RESET.
  - Outputs after reset: irq_req=0, dout per addr.
- CSR map:
  - mstatus 0x300: bit3 MIE, bit7 MPIE, bits12:11 MPP read 2'b11, others 0.
  - mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344 (read-only).
  - Unmapped addresses read 0; writes to them are ignored.
- Reads: purely combinational, zero latency.
- Writes: take effect on the next rising clk edge.
- Write masking:
  - mie and mip expose only implemented bits; unimplemented bits read 0 and ignore writes.
  - mtvec[1:0] and mepc[1:0] are forced to 0 (direct mode only).
- mip: each implemented bit is a registered copy of its irq line (1-cycle latency); software writes are ignored.
- Interrupt request:
  - pend = mip & mie.
  - irq_req = MIE & |pend.
  - Priority: MEI (code 11) > MTI (code 7) > platform bits, lowest index first.
  - irq_cause is undefined when irq_req=0.
- Trap (trap=1): MPIE<=MIE, MIE<=0, mepc<=trap_pc & ~3, mcause<=trap_cause.
- mret (mret=1, trap=0): MIE<=MPIE, MPIE<=1.
- Simultaneous events:
  - trap and mret in the same cycle: trap wins, mret is ignored.
  - trap with we to mstatus/mepc/mcause: trap updates win for those registers.
  - we to any other CSR still completes.
  - mret with we to mstatus: mret wins for MIE/MPIE.
- reset asserted mid-sequence: all registers return to reset values on that edge, regardless of trap, mret or we.

Optional Feature:
- Macro: CSR_COUNTERS_EN.
- Defined:
  - 64-bit mcycle (0xB00 low, 0xB80 high) increments every cycle.
  - 64-bit minstret (0xB02 low, 0xB82 high) increments when instret=1.
  - Both are cleared by reset and carry across the 32-bit boundary.
  - A write to either half loads that half with din, keeps the other half, and suppresses that counter's increment in that cycle.
- Not defined: those addresses read 0, writes are ignored, and no counter logic is synthesised.

Test Plan:
- Reset, then read every mapped CSR -> mtvec=32'h2000, all others 0 except mstatus=32'h1800; irq_req=0.
- Write mie=32'h880, mstatus=32'h8, then raise irq[0] -> mip reads 32'h80 one cycle later; irq_req=1; irq_cause=32'h80000007.
- Raise irq[0] and irq[1] together -> irq_cause=32'h8000000B.
- Pulse trap with trap_pc=32'h1236, trap_cause=32'h8000000B -> mepc=32'h1234, mcause=32'h8000000B, mstatus=32'h1880, irq_req=0.
  - Then pulse mret -> mstatus=32'h1888.
- Pulse trap and mret in the same cycle with we to mepc (din=32'h4000) -> mepc=trap_pc & ~3, MIE=0 (trap wins).
- CSR_COUNTERS_EN defined:
  - Write 0xB00=32'hFFFFFFFF, then idle 2 cycles -> mcycleh=1, mcycle=1.
  - Pulse instret 3 times -> minstret=3.
  - Without the macro, 0xB00 reads 0.
